// File: rtl/mult_hilo_unit_pkg.sv
// rtl/mult_hilo_unit_pkg.sv - shared constants and state encoding for the HI/LO multiplier
package mult_hilo_unit_pkg;

    localparam int WIDTH_DEF = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

endpackage

// File: rtl/mult_hilo_datapath.sv
// rtl/mult_hilo_datapath.sv - shift-add accumulator, multiplier shifter and sign fix-up
module mult_hilo_datapath
    import mult_hilo_unit_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               load,
    input  logic               step,
    input  logic               fix,
    input  logic               is_signed,
    input  logic [WIDTH-1:0]   op_a,
    input  logic [WIDTH-1:0]   op_b,
    output logic [2*WIDTH-1:0] product
);

    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] acc;
    logic               neg;

    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic               a_neg;
    logic               b_neg;
    logic               prod_neg;
    logic [WIDTH:0]     sum;

    // Operand magnitudes; the most-negative value maps onto itself, which is
    // the correct unsigned magnitude. A zero operand forces a positive result.
    always_comb begin
        a_neg    = is_signed & op_a[WIDTH-1];
        b_neg    = is_signed & op_b[WIDTH-1];
        a_mag    = a_neg ? (~op_a + WIDTH'(1)) : op_a;
        b_mag    = b_neg ? (~op_b + WIDTH'(1)) : op_b;
        prod_neg = (a_neg ^ b_neg) & (|op_a) & (|op_b);
    end

    // Upper-half add with carry kept, and the final signed result presented to the top
    always_comb begin
        sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (mplier[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
        product = neg ? (~acc + (2*WIDTH)'(1)) : acc;
    end

    // Iteration registers: capture on load, shift-add on step, clear after the result is taken
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            neg    <= 1'b0;
        end else if (load) begin
            mcand  <= a_mag;
            mplier <= b_mag;
            acc    <= '0;
            neg    <= prod_neg;
        end else if (step) begin
            acc    <= {sum, acc[WIDTH-1:1]};
            mplier <= mplier >> 1;
        end else if (fix) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            neg    <= 1'b0;
        end
    end

endmodule

// File: rtl/mult_hilo_unit.sv
// rtl/mult_hilo_unit.sv - sequential MULT/MULTU unit with architectural HI/LO registers
module mult_hilo_unit
    import mult_hilo_unit_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    state_t             state;
    state_t             next_state;
    logic [CNT_W-1:0]   cnt;
    logic               load;
    logic               step;
    logic               fix;
    logic               mt_ok;
    logic [2*WIDTH-1:0] product;

    mult_hilo_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .clk       (clk),
        .reset_n   (reset_n),
        .load      (load),
        .step      (step),
        .fix       (fix),
        .is_signed (is_signed),
        .op_a      (op_a),
        .op_b      (op_b),
        .product   (product)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state: WIDTH iterations in CALC, then a single fix-up cycle
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    next_state = start ? CALC : IDLE;
            CALC:    next_state = (cnt == CNT_W'(WIDTH - 1)) ? FIX : CALC;
            FIX:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Control strobes; MTHI/MTLO only land in IDLE when no multiply is starting
    always_comb begin
        load  = (state == IDLE) & start;
        step  = (state == CALC);
        fix   = (state == FIX);
        mt_ok = (state == IDLE) & ~start;
    end

    // Iteration counter, registered status flags and the HI/LO registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt  <= '0;
            busy <= 1'b0;
            done <= 1'b0;
            hi   <= '0;
            lo   <= '0;
        end else begin
            busy <= (next_state != IDLE);
            done <= fix;
            if (load) begin
                cnt <= '0;
            end else if (step) begin
                cnt <= cnt + CNT_W'(1);
            end
            if (fix) begin
                hi <= product[2*WIDTH-1:WIDTH];
                lo <= product[WIDTH-1:0];
            end else if (mt_ok) begin
                if (hi_we) begin
                    hi <= wdata;
                end
                if (lo_we) begin
                    lo <= wdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_mult_hilo_unit.sv
// tb/tb_mult_hilo_unit.sv - self-checking bench for mult_hilo_unit
module tb_mult_hilo_unit;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic        is_signed;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_vec;
    int n_err;

    mult_hilo_unit dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .is_signed (is_signed),
        .op_a      (op_a),
        .op_b      (op_b),
        .hi_we     (hi_we),
        .lo_we     (lo_we),
        .wdata     (wdata),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        s;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] ref_prod(input logic s, input logic [31:0] a, input logic [31:0] b);
        longint          sa;
        longint          sb;
        longint unsigned ua;
        longint unsigned ub;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return 64'(sa * sb);
        end
        ua = {32'd0, a};
        ub = {32'd0, b};
        return 64'(ua * ub);
    endfunction

    // Starts a multiply in the current cycle and follows it to its done pulse.
    // With intrude set, start/MTHI/MTLO are hammered mid-calculation.
    task automatic do_mul(input string name, input logic s, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp, input bit intrude);
        logic [31:0] old_hi;
        logic [31:0] old_lo;
        int          t;
        int          busy_cnt;
        bit          held;
        old_hi    = hi;
        old_lo    = lo;
        start     = 1'b1;
        is_signed = s;
        op_a      = a;
        op_b      = b;
        tick();
        start     = 1'b0;
        is_signed = $urandom_range(0, 1);
        op_a      = $urandom;
        op_b      = $urandom;
        t         = 0;
        busy_cnt  = 0;
        held      = 1'b1;
        while (!done && t < 40) begin
            if (busy) busy_cnt++;
            if (hi !== old_hi || lo !== old_lo) held = 1'b0;
            if (intrude && t == 5) begin
                start = 1'b1;
                hi_we = 1'b1;
                lo_we = 1'b1;
                wdata = 32'hDEADBEEF;
                op_a  = 32'h0000FFFF;
                op_b  = 32'h0000FFFF;
            end
            if (intrude && t == 9) begin
                start = 1'b0;
                hi_we = 1'b0;
                lo_we = 1'b0;
            end
            tick();
            t++;
        end
        check({name, " latency"}, 64'(t), 64'd33);
        check({name, " busy cycles"}, 64'(busy_cnt), 64'd33);
        check({name, " hold"}, {63'd0, held}, 64'd1);
        check({name, " busy at done"}, {63'd0, busy}, 64'd0);
        check({name, " product"}, {hi, lo}, exp);
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rs;
        int          pulses;

        n_vec     = 0;
        n_err     = 0;
        reset_n   = 1'b0;
        start     = 1'b0;
        is_signed = 1'b0;
        op_a      = '0;
        op_b      = '0;
        hi_we     = 1'b0;
        lo_we     = 1'b0;
        wdata     = '0;

        tbl.push_back('{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001});
        tbl.push_back('{1'b1, 32'hFFFFFFFE, 32'h00000003, 64'hFFFFFFFF_FFFFFFFA});
        tbl.push_back('{1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h00000000_00000001});
        tbl.push_back('{1'b1, 32'h80000000, 32'h80000000, 64'h40000000_00000000});
        tbl.push_back('{1'b0, 32'h80000000, 32'h80000000, 64'h40000000_00000000});
        tbl.push_back('{1'b0, 32'h00000007, 32'h00000009, 64'h00000000_0000003F});
        tbl.push_back('{1'b1, 32'h00000000, 32'hFFFFFFFB, 64'h00000000_00000000});
        tbl.push_back('{1'b1, 32'h80000000, 32'h00000001, 64'hFFFFFFFF_80000000});
        tbl.push_back('{1'b1, 32'h7FFFFFFF, 32'h80000000, 64'hC0000000_80000000});
        tbl.push_back('{1'b0, 32'h00000000, 32'h00000000, 64'h00000000_00000000});

        tick();
        tick();
        check("reset hi", {32'd0, hi}, 64'd0);
        check("reset lo", {32'd0, lo}, 64'd0);
        check("reset busy", {63'd0, busy}, 64'd0);
        check("reset done", {63'd0, done}, 64'd0);
        reset_n = 1'b1;
        tick();

        hi_we = 1'b1;
        lo_we = 1'b1;
        wdata = 32'h12345678;
        tick();
        hi_we = 1'b0;
        lo_we = 1'b0;
        check("mt both", {hi, lo}, 64'h12345678_12345678);

        // Consecutive table entries start in the done cycle of the previous one
        foreach (tbl[i]) begin
            do_mul($sformatf("tbl%0d", i), tbl[i].s, tbl[i].a, tbl[i].b, tbl[i].exp, 1'b0);
        end
        tick();
        check("done one cycle", {63'd0, done}, 64'd0);

        do_mul("intrude", 1'b0, 32'h00001234, 32'h00005678, 64'h00000000_06260060, 1'b1);
        tick();
        check("intrude no restart", {63'd0, busy}, 64'd0);

        hi_we = 1'b1;
        lo_we = 1'b1;
        wdata = 32'h11111111;
        tick();
        hi_we = 1'b0;
        start = 1'b1;
        is_signed = 1'b0;
        op_a  = 32'd3;
        op_b  = 32'd4;
        wdata = 32'hDEADBEEF;
        tick();
        start = 1'b0;
        lo_we = 1'b0;
        check("start beats mtlo", {hi, lo}, 64'h11111111_11111111);
        pulses = 0;
        while (!done && pulses < 40) begin
            tick();
            pulses++;
        end
        check("start+lo_we product", {hi, lo}, 64'd12);
        tick();

        start     = 1'b1;
        is_signed = 1'b0;
        op_a      = 32'd7;
        op_b      = 32'd9;
        tick();
        start = 1'b0;
        repeat (9) tick();
        reset_n = 1'b0;
        tick();
        check("midreset hi", {32'd0, hi}, 64'd0);
        check("midreset lo", {32'd0, lo}, 64'd0);
        check("midreset busy", {63'd0, busy}, 64'd0);
        reset_n = 1'b1;
        pulses = 0;
        repeat (40) begin
            if (done || busy) pulses++;
            tick();
        end
        check("midreset no done", 64'(pulses), 64'd0);
        do_mul("after reset", 1'b0, 32'd7, 32'd9, 64'd63, 1'b0);

        for (int i = 0; i < 200; i++) begin
            rs = $urandom_range(0, 1);
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: ra = 32'h80000000;
                1: rb = 32'hFFFFFFFF;
                2: ra = 32'd0;
                default: ;
            endcase
            do_mul($sformatf("rnd%0d", i), rs, ra, rb, ref_prod(rs, ra, rb), 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mult_hilo_unit.md
Name: mult_hilo_unit

Overview:
- Sequential shift-add multiplier with architectural HI/LO registers for MIPS MULT/MULTU/MFHI/MFLO/MTHI/MTLO.
- Sits beside the 32-bit ALU in the execute stage. It consumes the same rs/rt operands, and its hi/lo outputs feed the writeback result mux alongside the ALU result.
- Operates over multiple cycles. The control unit stalls PC update while busy is high.

Parameters:
- WIDTH, 32, operand width; hi and lo are each WIDTH bits; must be ≥ 2.
- CNT_W, $clog2(WIDTH)+1, iteration counter width; derived, never overridden.

Ports:
- clk  input  1  system clock, rising-edge.
- reset_n  input  1  synchronous, active-low reset.
- start  input  1  request a multiply; sampled only in IDLE.
- is_signed  input  1  1 = MULT (two's complement), 0 = MULTU; captured with start.
- op_a  input  WIDTH  multiplicand (rs); captured with start.
- op_b  input  WIDTH  multiplier (rt); captured with start.
- hi_we  input  1  MTHI: write wdata into hi.
- lo_we  input  1  MTLO: write wdata into lo.
- wdata  input  WIDTH  data for MTHI/MTLO.
- busy  output  1  high while a multiply is in progress.
- done  output  1  one-cycle pulse when hi/lo receive a new product.
- hi  output  WIDTH  HI register (upper product half).
- lo  output  WIDTH  LO register (lower product half).

Behaviour:
- Reset:
  - reset_n=0 at a clock edge forces state=IDLE, hi=0, lo=0, busy=0, done=0, counter=0, accumulator=0.
  - Reset overrides every other input, including mid-operation; a partial product is discarded.
- States: IDLE, CALC, FIX. All outputs are registered.
- IDLE:
  - start=1 at edge k captures magnitudes |op_a| and |op_b| (magnitude taken only when is_signed=1), captures result sign = a_msb XOR b_msb (signed only), clears the 2*WIDTH accumulator and counter, and moves to CALC.
  - busy=1 from cycle k+1.
  - If start=0, hi_we/lo_we write wdata into hi/lo on the edge; both may be written in the same cycle.
  - If start=1 and hi_we or lo_we=1 in the same cycle, start wins and the writes are dropped.
- CALC:
  - One iteration per edge: if multiplier LSB=1, add multiplicand into the upper half of the accumulator (WIDTH+1-bit sum, keeping the carry); shift the accumulator right by 1 and the multiplier right by 1.
  - After exactly WIDTH iterations (edges k+1..k+WIDTH), move to FIX.
- FIX:
  - At edge k+WIDTH+1, hi:lo <= sign ? two's-complement negation of accumulator : accumulator.
  - done=1 for exactly that following cycle; busy=0; state returns to IDLE.
- Latency: start at edge k gives a new hi/lo visible after edge k+WIDTH+1 (33 for WIDTH=32).
- While busy:
  - start, hi_we and lo_we are ignored.
  - hi/lo hold their old values until FIX.
- Back-to-back: start may be asserted in the cycle done=1 (state is IDLE); the next operation begins immediately.
- Arithmetic:
  - The full 2*WIDTH product is exact with no overflow.
  - The most-negative operand (0x80000000) has magnitude 0x80000000 as an unsigned value, which is handled correctly.
  - A zero operand yields 0 with sign forced positive, so no negative zero.

Decomposition:
- Shared package holds:
  - state encoding constants: IDLE=2'd0, CALC=2'd1, FIX=2'd2.
  - the WIDTH default of 32.
- One natural sub-module: mult_hilo_datapath. It holds the accumulator, multiplier shift register, conditional adder, and final negation, under FSM control signals load/step/fix.
- The FSM, counter and HI/LO registers stay in the top module.

Test Plan:
- Reset mid-op: start with 7*9 unsigned, assert reset_n=0 at cycle 10 -> hi=0, lo=0, busy=0, done never pulses, and a fresh start still works.
- Unsigned extreme: MULTU 0xFFFFFFFF*0xFFFFFFFF -> after exactly 33 cycles hi=0xFFFFFFFE, lo=0x00000001, done high 1 cycle, busy high cycles 1..33.
- Signed mixed: MULT 0xFFFFFFFE(-2)*0x00000003 -> hi=0xFFFFFFFF, lo=0xFFFFFFFA. Then MULT -1*-1 -> hi=0, lo=1.
- Most-negative: MULT 0x80000000*0x80000000 -> hi=0x40000000, lo=0. MULTU of the same operands -> also hi=0x40000000, lo=0.
- Busy protection: during CALC assert start with new operands plus hi_we/lo_we with wdata=0xDEADBEEF -> ignored; hi/lo hold the old values until FIX, then equal the original product only.
- MT/priority/back-to-back:
  - In IDLE, hi_we=1 and lo_we=1 with wdata=0x12345678 -> both hi and lo read 0x12345678 next cycle.
  - start with lo_we in the same cycle -> write dropped.
  - start asserted during the done cycle -> the second product lands exactly 33 cycles later.
